// File: rtl/alu_seq_pkg.sv
// Purpose: shared state encodings and default widths for the ALU front-panel sequencer, the ALU and the LED decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

   localparam int STAGE_W      = 3;
   localparam int DEF_WIDTH    = 8;
   localparam int DEF_OP_WIDTH = 4;

   // Codes 6 and 7 are never entered; the sequencer sends them back to S_A.
   typedef enum logic [STAGE_W-1:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_WAIT = 3'd4,
      S_SHOW = 3'd5
   } state_t;

endpackage

// File: rtl/alu_input_sequencer_edge_pulse.sv
// Purpose: rising-edge detector turning a debounced button level into a one-cycle press.
// Latency: combinational pulse in the cycle the level first reads 1 after a 0.
// Backpressure: none; a held level gives one pulse and re-arms only after a 0 cycle.
module edge_pulse (
   input  logic Clk,
   input  logic Reset,
   input  logic level,
   output logic pulse
);

   logic r_prev;

   // Previous level resets to 1 so a button held through reset release is not a press.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_prev <= 1'b1;
      end else begin
         r_prev <= level;
      end
   end

   assign pulse = level & ~r_prev;

endmodule

// File: rtl/alu_input_sequencer.sv
// Purpose: front-panel entry sequencer: latches operand A, operand B, opcode, strobes the ALU, shows the result.
// Latency: operands latch on the press edge; alu_start one edge after the opcode press; done honoured from the next edge.
// Backpressure: none; presses in states that do not consume them are dropped, alu_done outside S_WAIT is ignored.
module alu_input_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int OP_WIDTH = DEF_OP_WIDTH
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                enter_in,
   input  logic                clear_in,
   input  logic [WIDTH-1:0]    sw_in,
   input  logic                alu_done,
   output logic [WIDTH-1:0]    op_a,
   output logic [WIDTH-1:0]    op_b,
   output logic [OP_WIDTH-1:0] opcode,
   output logic                alu_start,
   output logic                result_valid,
   output logic [STAGE_W-1:0]  stage
);

   logic w_enter_press;
   logic w_clear_press;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WIDTH-1:0]    r_op_a;
   logic [WIDTH-1:0]    w_op_a_nxt;
   logic [WIDTH-1:0]    r_op_b;
   logic [WIDTH-1:0]    w_op_b_nxt;
   logic [OP_WIDTH-1:0] r_opcode;
   logic [OP_WIDTH-1:0] w_opcode_nxt;

   edge_pulse u_enter_edge (
      .Clk   (Clk),
      .Reset (Reset),
      .level (enter_in),
      .pulse (w_enter_press)
   );

   edge_pulse u_clear_edge (
      .Clk   (Clk),
      .Reset (Reset),
      .level (clear_in),
      .pulse (w_clear_press)
   );

   // State and latched operand registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state  <= S_A;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_opcode <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_op_a   <= w_op_a_nxt;
         r_op_b   <= w_op_b_nxt;
         r_opcode <= w_opcode_nxt;
      end
   end

   // Next state and operand capture; clear outranks enter and alu_done.
   always_comb begin
      w_state_nxt  = r_state;
      w_op_a_nxt   = r_op_a;
      w_op_b_nxt   = r_op_b;
      w_opcode_nxt = r_opcode;
      if (w_clear_press) begin
         w_state_nxt  = S_A;
         w_op_a_nxt   = '0;
         w_op_b_nxt   = '0;
         w_opcode_nxt = '0;
      end else begin
         case (r_state)
            S_A: begin
               if (w_enter_press) begin
                  w_op_a_nxt  = sw_in;
                  w_state_nxt = S_B;
               end
            end
            S_B: begin
               if (w_enter_press) begin
                  w_op_b_nxt  = sw_in;
                  w_state_nxt = S_OP;
               end
            end
            S_OP: begin
               if (w_enter_press) begin
                  w_opcode_nxt = sw_in[OP_WIDTH-1:0];
                  w_state_nxt  = S_EXEC;
               end
            end
            S_EXEC: begin
               w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (alu_done) begin
                  w_state_nxt = S_SHOW;
               end
            end
            S_SHOW: begin
               if (w_enter_press) begin
                  w_state_nxt = S_A;
               end
            end
            default: begin
               w_state_nxt = S_A;
            end
         endcase
      end
   end

   // Outputs decode straight from registers, so the start strobe cannot glitch.
   assign alu_start    = (r_state == S_EXEC);
   assign result_valid = (r_state == S_SHOW);
   assign stage        = r_state;
   assign op_a         = r_op_a;
   assign op_b         = r_op_b;
   assign opcode       = r_opcode;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Purpose: directed self-checking bench for alu_input_sequencer.
// Latency: inputs change and outputs are sampled 1 ns after each rising edge.
// Backpressure: n/a.
module tb_alu_input_sequencer;

   logic       Clk;
   logic       Reset;
   logic       enter_in;
   logic       clear_in;
   logic [7:0] sw_in;
   logic       alu_done;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [3:0] opcode;
   logic       alu_start;
   logic       result_valid;
   logic [2:0] stage;

   int n_checks;
   int n_fail;

   alu_input_sequencer #(.WIDTH(8), .OP_WIDTH(4)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .enter_in     (enter_in),
      .clear_in     (clear_in),
      .sw_in        (sw_in),
      .alu_done     (alu_done),
      .op_a         (op_a),
      .op_b         (op_b),
      .opcode       (opcode),
      .alu_start    (alu_start),
      .result_valid (result_valid),
      .stage        (stage)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Enter high across one edge, then dropped; caller ticks once more to re-arm.
   task automatic press_enter(input logic [7:0] val);
      sw_in    = val;
      enter_in = 1'b1;
      tick();
      enter_in = 1'b0;
   endtask

   task automatic press_clear();
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      Reset    = 1'b0;
      enter_in = 1'b0;
      clear_in = 1'b0;
      sw_in    = 8'h00;
      alu_done = 1'b0;

      // Reset state
      tick();
      check_eq("rst_stage", stage, 0);
      check_eq("rst_op_a", op_a, 0);
      check_eq("rst_start", alu_start, 0);
      check_eq("rst_rv", result_valid, 0);
      Reset = 1'b1;
      tick();
      tick();

      // Full sequence
      press_enter(8'h12);
      check_eq("seq_stage1", stage, 1);
      check_eq("seq_op_a", op_a, 8'h12);
      tick();
      press_enter(8'h34);
      check_eq("seq_stage2", stage, 2);
      check_eq("seq_op_b", op_b, 8'h34);
      check_eq("seq_start_early", alu_start, 0);
      tick();
      press_enter(8'h05);
      check_eq("seq_stage3", stage, 3);
      check_eq("seq_opcode", opcode, 4'h5);
      check_eq("seq_start_hi", alu_start, 1);
      tick();
      check_eq("seq_stage4", stage, 4);
      check_eq("seq_start_lo", alu_start, 0);
      // Enter in S_WAIT is ignored
      press_enter(8'hFF);
      check_eq("wait_enter_stage", stage, 4);
      check_eq("wait_enter_op_a", op_a, 8'h12);
      tick();
      tick();
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      check_eq("seq_show_stage", stage, 5);
      check_eq("seq_show_rv", result_valid, 1);
      press_enter(8'h77);
      check_eq("seq_back_stage", stage, 0);
      check_eq("seq_back_rv", result_valid, 0);
      check_eq("seq_retain_op_a", op_a, 8'h12);
      check_eq("seq_retain_op_b", op_b, 8'h34);
      tick();

      // Held at reset
      Reset    = 1'b0;
      enter_in = 1'b1;
      sw_in    = 8'h99;
      tick();
      Reset = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check_eq("held_stage", stage, 0);
      check_eq("held_op_a", op_a, 0);
      enter_in = 1'b0;
      tick();
      press_enter(8'hA5);
      check_eq("held_rearm_stage", stage, 1);
      check_eq("held_rearm_op_a", op_a, 8'hA5);

      // alu_done in S_B is ignored
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      check_eq("done_in_b_stage", stage, 1);
      check_eq("done_in_b_op_b", op_b, 0);

      // Clear mid-entry in S_OP
      press_enter(8'h5A);
      check_eq("clr_pre_stage", stage, 2);
      tick();
      press_clear();
      check_eq("clr_stage", stage, 0);
      check_eq("clr_op_a", op_a, 0);
      check_eq("clr_op_b", op_b, 0);
      tick();

      // Enter and clear together: clear wins
      press_enter(8'h11);
      check_eq("both_pre_stage", stage, 1);
      tick();
      sw_in    = 8'h22;
      enter_in = 1'b1;
      clear_in = 1'b1;
      tick();
      enter_in = 1'b0;
      clear_in = 1'b0;
      check_eq("both_stage", stage, 0);
      check_eq("both_op_a", op_a, 0);
      check_eq("both_op_b", op_b, 0);
      tick();

      // Abort in S_WAIT, late done
      press_enter(8'h01);
      tick();
      press_enter(8'h02);
      tick();
      press_enter(8'h03);
      tick();
      check_eq("abort_pre_stage", stage, 4);
      press_clear();
      check_eq("abort_stage", stage, 0);
      check_eq("abort_opcode", opcode, 0);
      tick();
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      check_eq("late_done_stage", stage, 0);
      check_eq("late_done_rv", result_valid, 0);
      tick();

      // Async reset in S_SHOW
      press_enter(8'h07);
      tick();
      press_enter(8'h08);
      tick();
      press_enter(8'h09);
      tick();
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      check_eq("ar_pre_stage", stage, 5);
      check_eq("ar_pre_op_a", op_a, 8'h07);
      #2;
      Reset = 1'b0;
      #1;
      check_eq("ar_stage", stage, 0);
      check_eq("ar_rv", result_valid, 0);
      check_eq("ar_op_a", op_a, 0);
      check_eq("ar_op_b", op_b, 0);
      check_eq("ar_opcode", opcode, 0);
      check_eq("ar_start", alu_start, 0);
      tick();
      Reset = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
